maxpool_stream: RTL and testbench

MAXPOOL_STREAM -- requirements
Module: maxpool_stream

---
 rtl/maxpool_stream.sv | 144 ++++++++++++++
 tb/tb_maxpool_stream.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_stream.sv
// 2x2 stride-2 max pooling over a raster pixel stream, one pixel per cycle.
// Latency: pooled result appears 1 cycle after the accept of the window's last pixel.
// Backpressure: in_ready = !out_valid || out_ready; a held result stalls input.
//
// Ports:
//   CLK, rst         clock (rising edge) and asynchronous active-high reset
//   in_valid/ready   input handshake; in_data is the pixel, in_sof forces (row 0, col 0)
//   out_valid/ready  output handshake; out_data is the window max, out_last marks
//                    the final window of a frame
module maxpool_stream #(
  parameter int DATAWIDTH = 64,
  parameter int IMG_W     = 8,
  parameter int IMG_H     = 8,
  parameter int SIGNED    = 0
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] in_data,
  input  logic                 in_sof,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] out_data,
  output logic                 out_last
);

  localparam int CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int LB_N = IMG_W / 2;
  localparam int LW   = (LB_N > 1) ? $clog2(LB_N) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  // Max of two pixels; on equality either operand is the same value.
  function automatic logic [DATAWIDTH-1:0] max2(input logic [DATAWIDTH-1:0] a,
                                                input logic [DATAWIDTH-1:0] b);
    logic a_gt;
    if (SIGNED != 0) a_gt = ($signed(a) > $signed(b));
    else             a_gt = (a > b);
    return a_gt ? a : b;
  endfunction

  logic                 accept;
  logic [CW-1:0]        col_q, col_d, cur_col;
  logic [RW-1:0]        row_q, row_d, cur_row;
  logic                 col_odd, row_odd;
  logic [DATAWIDTH-1:0] hold_q, hold_d;
  logic [DATAWIDTH-1:0] pair;
  logic [DATAWIDTH-1:0] lb_rd;
  logic [LW-1:0]        lb_idx;
  logic                 lb_we;
  logic                 win_done;
  logic                 out_valid_q, out_valid_d;
  logic                 out_last_q, out_last_d;
  logic [DATAWIDTH-1:0] out_data_q, out_data_d;

  // Horizontal pair maxima of the even row, one entry per window column.
  logic [DATAWIDTH-1:0] linebuf_q [LB_N];

  // A completing window always lands in a slot that is free or being drained
  // this cycle, so the output register never needs a skid buffer.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // in_sof overrides the counters so the current pixel is treated as (0,0);
  // any partial window is simply overwritten by the restarted frame.
  assign cur_col = in_sof ? '0 : col_q;
  assign cur_row = in_sof ? '0 : row_q;
  assign col_odd = cur_col[0];
  assign row_odd = cur_row[0];

  assign lb_idx   = LW'(cur_col >> 1);
  assign lb_rd    = linebuf_q[lb_idx];
  assign pair     = max2(hold_q, in_data);
  assign lb_we    = accept && col_odd && !row_odd;
  assign win_done = accept && col_odd && row_odd;

  // Raster position counters.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
      end else begin
        col_d = cur_col + 1'b1;
        row_d = cur_row;
      end
    end
  end

  // Even-column pixel waits here for its odd-column partner.
  always_comb begin
    hold_d = hold_q;
    if (accept && !col_odd) hold_d = in_data;
  end

  // Output register: load on window completion (even if the previous result is
  // being taken this same cycle), otherwise drop valid once it is consumed.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (win_done) begin
      out_valid_d = 1'b1;
      out_data_d  = max2(pair, lb_rd);
      out_last_d  = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      hold_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      hold_q      <= hold_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  // No reset: every entry is written on the even row before the odd row reads it.
  always_ff @(posedge CLK) begin
    if (lb_we) linebuf_q[lb_idx] <= pair;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_maxpool_stream.sv
// Directed and randomized checks of maxpool_stream on small unsigned/signed
// 4x2 images and on three back-to-back 8x8 frames with random handshakes.
module tb_maxpool_stream;

  logic CLK = 1'b0;
  logic rst = 1'b1;

  // Shared stimulus for the two 4x2 instances (unsigned A, signed B).
  logic       in_valid  = 1'b0;
  logic       in_sof    = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] in_data   = 8'd0;

  logic       a_in_ready, a_out_valid, a_out_last;
  logic [7:0] a_out_data;
  logic       b_in_ready, b_out_valid, b_out_last;
  logic [7:0] b_out_data;

  // 8x8 random-frame instance.
  logic        c_in_valid  = 1'b0;
  logic        c_in_sof    = 1'b0;
  logic        c_out_ready = 1'b1;
  logic [15:0] c_in_data   = 16'd0;
  logic        c_in_ready, c_out_valid, c_out_last;
  logic [15:0] c_out_data;

  int n_checks = 0;
  int n_err    = 0;
  int n_out    = 0;
  int n_last   = 0;
  logic rnd_on = 1'b0;

  logic [15:0] exp_d [$];
  logic        exp_l [$];
  logic [15:0] rpix  [3][64];
  logic [7:0]  px    [8];

  maxpool_stream #(.DATAWIDTH(8), .IMG_W(4), .IMG_H(2), .SIGNED(0)) u_a (
    .CLK(CLK), .rst(rst),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data), .in_sof(in_sof),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data), .out_last(a_out_last)
  );

  maxpool_stream #(.DATAWIDTH(8), .IMG_W(4), .IMG_H(2), .SIGNED(1)) u_b (
    .CLK(CLK), .rst(rst),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data), .in_sof(in_sof),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data), .out_last(b_out_last)
  );

  maxpool_stream #(.DATAWIDTH(16), .IMG_W(8), .IMG_H(8), .SIGNED(0)) u_c (
    .CLK(CLK), .rst(rst),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data), .in_sof(c_in_sof),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data), .out_last(c_out_last)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one pixel for exactly one rising edge (caller ensures in_ready).
  task automatic push(input logic [7:0] d, input logic sof);
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = sof;
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  // Stream one 4x2 frame with out_ready=1; windows complete on pixels 5 and 7.
  task automatic run_frame(input string tag, input logic [7:0] pix [8], input logic sof0,
                           input logic [7:0] ea0, input logic [7:0] ea1,
                           input logic chk_b, input logic [7:0] eb0, input logic [7:0] eb1);
    for (int i = 0; i < 8; i++) begin
      logic win;
      win = (i == 5) || (i == 7);
      push(pix[i], sof0 && (i == 0));
      check($sformatf("%s_v%0d", tag, i), 64'(a_out_valid), 64'(win));
      if (win) begin
        check($sformatf("%s_d%0d", tag, i), 64'(a_out_data), 64'((i == 7) ? ea1 : ea0));
        check($sformatf("%s_l%0d", tag, i), 64'(a_out_last), 64'(i == 7));
      end
      if (chk_b) begin
        check($sformatf("%s_bv%0d", tag, i), 64'(b_out_valid), 64'(win));
        if (win) begin
          check($sformatf("%s_bd%0d", tag, i), 64'(b_out_data), 64'((i == 7) ? eb1 : eb0));
          check($sformatf("%s_bl%0d", tag, i), 64'(b_out_last), 64'(i == 7));
        end
      end
    end
    @(posedge CLK);
    #1;
    check({tag, "_idle"}, 64'(a_out_valid), 64'd0);
  endtask

  // Random downstream readiness for the 8x8 instance.
  always begin
    @(posedge CLK);
    #1;
    if (rnd_on) c_out_ready = ($urandom_range(0, 3) != 0);
  end

  // Scoreboard: a transfer happens on the next edge when valid&&ready here.
  always @(negedge CLK) begin
    if (c_out_valid && c_out_ready) begin
      n_out++;
      if (c_out_last) n_last++;
      if (exp_d.size() == 0) begin
        check("rnd_extra", 64'(exp_d.size()), 64'd1);
      end else begin
        check("rnd_data", 64'(c_out_data), 64'(exp_d.pop_front()));
        check("rnd_last", 64'(c_out_last), 64'(exp_l.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached with errors=%0d of %0d checks", n_err, n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state.
    repeat (2) @(posedge CLK);
    #1;
    check("rst_valid", 64'(a_out_valid), 64'd0);
    check("rst_data",  64'(a_out_data),  64'd0);
    check("rst_last",  64'(a_out_last),  64'd0);
    check("rst_rdy",   64'(a_in_ready),  64'd1);
    rst = 1'b0;

    // Basic frame: windows {1,9,7,2} -> 9 and {3,4,8,0} -> 8.
    px = '{8'd1, 8'd9, 8'd3, 8'd4, 8'd7, 8'd2, 8'd8, 8'd0};
    run_frame("basic", px, 1'b1, 8'd9, 8'd8, 1'b0, 8'd0, 8'd0);

    // Signed vs unsigned compare.
    px = '{8'h80, 8'hFF, 8'h7F, 8'h80, 8'h81, 8'hFE, 8'h01, 8'hFF};
    run_frame("sgn", px, 1'b1, 8'hFF, 8'hFF, 1'b1, 8'hFF, 8'h7F);

    // Mid-frame resync: three stray pixels, then in_sof restarts the frame.
    push(8'd50, 1'b1);
    check("rsync_pre0", 64'(a_out_valid), 64'd0);
    push(8'd60, 1'b0);
    check("rsync_pre1", 64'(a_out_valid), 64'd0);
    push(8'd70, 1'b0);
    check("rsync_pre2", 64'(a_out_valid), 64'd0);
    px = '{8'd1, 8'd9, 8'd3, 8'd4, 8'd7, 8'd2, 8'd8, 8'd0};
    run_frame("rsync", px, 1'b1, 8'd9, 8'd8, 1'b0, 8'd0, 8'd0);

    // Backpressure: first result held, input stalled until out_ready returns.
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(px[i], i == 0);
    check("bp_v",   64'(a_out_valid), 64'd1);
    check("bp_d",   64'(a_out_data),  64'd9);
    check("bp_l",   64'(a_out_last),  64'd0);
    check("bp_rdy", 64'(a_in_ready),  64'd0);
    in_valid = 1'b1;
    in_data  = 8'd8;
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK);
      #1;
      check($sformatf("bp_hold_d%0d", k), 64'(a_out_data),  64'd9);
      check($sformatf("bp_hold_v%0d", k), 64'(a_out_valid), 64'd1);
      check($sformatf("bp_hold_r%0d", k), 64'(a_in_ready),  64'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_rdy_up", 64'(a_in_ready), 64'd1);
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    check("bp_drain", 64'(a_out_valid), 64'd0);
    push(8'd0, 1'b0);
    check("bp_v2", 64'(a_out_valid), 64'd1);
    check("bp_d2", 64'(a_out_data),  64'd8);
    check("bp_l2", 64'(a_out_last),  64'd1);
    @(posedge CLK);
    #1;
    check("bp_idle", 64'(a_out_valid), 64'd0);

    // Asynchronous reset between edges while a result is held.
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(px[i], i == 0);
    check("ar_v_pre", 64'(a_out_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_v",    64'(a_out_valid), 64'd0);
    check("ar_d",    64'(a_out_data),  64'd0);
    check("ar_l",    64'(a_out_last),  64'd0);
    check("ar_rdy",  64'(a_in_ready),  64'd1);
    check("ar_brdy", 64'(b_in_ready),  64'd1);
    @(posedge CLK);
    #1;
    check("ar_v_hold", 64'(a_out_valid), 64'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    // No in_sof: the first accept after reset must be (0,0).
    px = '{8'd5, 8'd2, 8'd3, 8'd11, 8'd4, 8'd1, 8'd10, 8'd6};
    run_frame("post_rst", px, 1'b0, 8'd5, 8'd11, 1'b0, 8'd0, 8'd0);

    // Three 8x8 frames with random gaps and random downstream stalls.
    for (int f = 0; f < 3; f++) begin
      for (int p = 0; p < 64; p++) rpix[f][p] = 16'($urandom);
      for (int wr = 0; wr < 4; wr++) begin
        for (int wc = 0; wc < 4; wc++) begin
          logic [15:0] m;
          m = rpix[f][(2 * wr) * 8 + 2 * wc];
          for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++)
              if (rpix[f][(2 * wr + dy) * 8 + 2 * wc + dx] > m)
                m = rpix[f][(2 * wr + dy) * 8 + 2 * wc + dx];
          exp_d.push_back(m);
          exp_l.push_back((wr == 3) && (wc == 3));
        end
      end
    end
    rnd_on = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int p = 0; p < 64; p++) begin
        logic acc;
        while ($urandom_range(0, 3) == 0) begin
          @(posedge CLK);
          #1;
        end
        c_in_valid = 1'b1;
        c_in_data  = rpix[f][p];
        c_in_sof   = (p == 0);
        acc = 1'b0;
        while (!acc) begin
          @(negedge CLK);
          acc = c_in_ready;
          @(posedge CLK);
          #1;
        end
        c_in_valid = 1'b0;
        c_in_sof   = 1'b0;
      end
    end
    for (int k = 0; k < 400 && exp_d.size() != 0; k++) @(posedge CLK);
    #1;
    rnd_on = 1'b0;
    c_out_ready = 1'b1;
    check("rnd_drain", 64'(exp_d.size()), 64'd0);
    check("rnd_count", 64'(n_out), 64'd48);
    check("rnd_lasts", 64'(n_last), 64'd3);
    repeat (2) @(posedge CLK);
    #1;
    check("rnd_idle", 64'(c_out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
